// File: rtl/m68k_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : m68k_bus_arbiter_if
//  Description : Bus-mastership handshake bundle between the 68K pins, the
//                Pi-side cycle engine and the bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface m68k_bus_arbiter_if;
    logic        br_n;          // M68K_BR_n pin, asynchronous
    logic        bgack_n;       // M68K_BGACK_n pin, asynchronous
    logic        as_n;          // engine's registered M68K_AS_n
    logic        engine_idle;   // engine waiting for a request
    logic        op_req_in;     // pending Pi transaction request
    logic        op_start;      // engine accepted the request
    logic        op_req_out;    // request forwarded to the engine
    logic        bg_n;          // M68K_BG_n
    logic        bus_drive_en;  // output enable for engine-driven bus pins
    logic        ext_owner;     // external master owns the bus
    logic [15:0] grant_count;   // completed external tenures, saturating

    // Environment side: pins and engine drive requests, observe arbitration
    modport master (
        output br_n, bgack_n, as_n, engine_idle, op_req_in, op_start,
        input  op_req_out, bg_n, bus_drive_en, ext_owner, grant_count
    );

    // Arbiter side
    modport slave (
        input  br_n, bgack_n, as_n, engine_idle, op_req_in, op_start,
        output op_req_out, bg_n, bus_drive_en, ext_owner, grant_count
    );
endinterface
`default_nettype wire

// File: rtl/m68k_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : m68k_bus_arbiter
//  Description : 68000 bus-mastership arbitration (BR/BG/BGACK) for the Pi
//                transaction engine. Decides each cycle whether the engine
//                may start a new bus cycle or an external DMA master gets
//                the bus, and gates the engine's bus drivers accordingly.
//  Revision    : 1.0 - initial release
// ============================================================================
module m68k_bus_arbiter #(
    parameter int SYNC_STAGES = 2,   // flops per input synchroniser (>= 2)
    parameter int BG_TIMEOUT  = 64,  // cycles BG may stay low after BR withdrawn
    parameter int HOLDOFF     = 8    // cycles after BGACK release before driving
) (
    input wire                c200m,
    input wire                reset,
    m68k_bus_arbiter_if.slave bus
);

    localparam int c_TO_W   = $clog2(BG_TIMEOUT + 1);
    localparam int c_HOLD_W = $clog2(HOLDOFF + 1);

    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(BG_TIMEOUT - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLDOFF - 1);
    localparam logic [15:0]         c_CNT_MAX   = 16'hFFFF;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WAIT    = 3'd1;
    localparam logic [2:0] c_ST_GRANT   = 3'd2;
    localparam logic [2:0] c_ST_OWNED   = 3'd3;
    localparam logic [2:0] c_ST_RELEASE = 3'd4;

    logic [SYNC_STAGES-1:0] r_br_sync;
    logic [SYNC_STAGES-1:0] r_bgack_sync;
    logic                   w_br_s;
    logic                   w_bgack_s;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [c_TO_W-1:0]   w_to_cnt_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_HOLD_W-1:0] w_hold_cnt_nxt;
    logic                r_pi_turn;
    logic                w_pi_turn_nxt;
    logic                w_cnt_inc;
    logic                r_bg_n;
    logic [15:0]         r_grant_count;
    logic                w_op_req;
    logic                w_drive_en;
    logic                w_ext_owner;

    // BR resets to "not requesting"; BGACK resets to "asserted" so the
    // drivers stay off after a reset until the pin is genuinely seen high.
    always_ff @(posedge c200m) begin
        if (reset) begin
            r_br_sync    <= '1;
            r_bgack_sync <= '0;
        end else begin
            r_br_sync    <= {r_br_sync[SYNC_STAGES-2:0], bus.br_n};
            r_bgack_sync <= {r_bgack_sync[SYNC_STAGES-2:0], bus.bgack_n};
        end
    end

    assign w_br_s    = r_br_sync[SYNC_STAGES-1];
    assign w_bgack_s = r_bgack_sync[SYNC_STAGES-1];

    // State, counters, registered BG and tenure counter
    always_ff @(posedge c200m) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_to_cnt      <= '0;
            r_hold_cnt    <= '0;
            r_pi_turn     <= 1'b0;
            r_bg_n        <= 1'b1;
            r_grant_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_pi_turn  <= w_pi_turn_nxt;
            // BG is low exactly while the next state is GRANT; taken from a
            // flop so the pin never glitches on a state decode.
            r_bg_n     <= (w_state_nxt != c_ST_GRANT);
            if (w_cnt_inc && (r_grant_count != c_CNT_MAX)) begin
                r_grant_count <= r_grant_count + 16'd1;
            end
        end
    end

    // Next-state decode and state-gated outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_to_cnt_nxt   = '0;
        w_hold_cnt_nxt = '0;
        w_pi_turn_nxt  = r_pi_turn;
        w_cnt_inc      = 1'b0;
        w_op_req       = 1'b0;
        w_drive_en     = 1'b0;
        w_ext_owner    = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_drive_en = w_bgack_s;
                w_op_req   = bus.op_req_in && w_bgack_s && (w_br_s || r_pi_turn);
                if (r_pi_turn) begin
                    // Pi owes one transaction: BR waits until it is accepted
                    // or the request goes away.
                    if (bus.op_start || !bus.op_req_in) begin
                        w_pi_turn_nxt = 1'b0;
                    end
                end else if (!w_br_s) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end

            c_ST_WAIT: begin
                // A cycle accepted as BR arrived is still on the bus, so the
                // drivers stay enabled until the grant is actually issued.
                w_drive_en = w_bgack_s;
                if (w_br_s) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (bus.engine_idle && bus.as_n && !bus.op_start) begin
                    w_state_nxt = c_ST_GRANT;
                end
            end

            c_ST_GRANT: begin
                if (!w_bgack_s) begin
                    w_state_nxt = c_ST_OWNED;
                end else if (w_br_s) begin
                    // Master withdrew BR without taking the bus
                    if (r_to_cnt == c_TO_LAST) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + 1'b1;
                    end
                end
            end

            c_ST_OWNED: begin
                w_ext_owner = 1'b1;
                if (w_bgack_s) begin
                    w_state_nxt = c_ST_RELEASE;
                end
            end

            c_ST_RELEASE: begin
                if (!w_bgack_s) begin
                    w_state_nxt = c_ST_OWNED;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_inc   = 1'b1;
                    if (bus.op_req_in) begin
                        w_pi_turn_nxt = 1'b1;
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign bus.op_req_out   = w_op_req;
    assign bus.bus_drive_en = w_drive_en;
    assign bus.ext_owner    = w_ext_owner;
    assign bus.bg_n         = r_bg_n;
    assign bus.grant_count  = r_grant_count;

endmodule
`default_nettype wire

// File: tb/tb_m68k_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m68k_bus_arbiter
//  Description : Directed self-checking bench for m68k_bus_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m68k_bus_arbiter;

    logic c200m;
    logic reset;
    int   n_total;
    int   n_bad;

    m68k_bus_arbiter_if bus_if ();

    m68k_bus_arbiter #(
        .SYNC_STAGES (2),
        .BG_TIMEOUT  (64),
        .HOLDOFF     (8)
    ) dut (
        .c200m (c200m),
        .reset (reset),
        .bus   (bus_if)
    );

    initial c200m = 1'b0;
    always #5 c200m = ~c200m;

    task automatic tick(input int n);
        repeat (n) @(posedge c200m);
        #1;
    endtask

    // Idle engine, no BR: one full external tenure, no checks
    task automatic run_tenure();
        bus_if.br_n = 1'b0;
        tick(4);
        bus_if.bgack_n = 1'b0;
        bus_if.br_n    = 1'b1;
        tick(3);
        bus_if.bgack_n = 1'b1;
        tick(11);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        n_total++;
        if (bus_if.bg_n !== 1'b1) begin
            n_bad++; $display("FAIL reset_bg_n: got %b want 1", bus_if.bg_n);
        end
        n_total++;
        if ({bus_if.op_req_out, bus_if.bus_drive_en, bus_if.ext_owner} !== 3'b000) begin
            n_bad++; $display("FAIL reset_outs: got %b want 000",
                {bus_if.op_req_out, bus_if.bus_drive_en, bus_if.ext_owner});
        end
        n_total++;
        if (bus_if.grant_count !== 16'd0) begin
            n_bad++; $display("FAIL reset_count: got %0d want 0", bus_if.grant_count);
        end
        reset = 1'b0;
        tick(3);
        n_total++;
        if (bus_if.bus_drive_en !== 1'b1) begin
            n_bad++; $display("FAIL reset_drive_on: got %b want 1", bus_if.bus_drive_en);
        end
    endtask

    task automatic test_basic_tenure();
        bus_if.br_n = 1'b0;
        tick(3);
        n_total++;
        if (bus_if.bg_n !== 1'b1) begin
            n_bad++; $display("FAIL basic_bg_early: got %b want 1", bus_if.bg_n);
        end
        tick(1);
        n_total++;
        if (bus_if.bg_n !== 1'b0) begin
            n_bad++; $display("FAIL basic_bg_latency: got %b want 0", bus_if.bg_n);
        end
        n_total++;
        if (bus_if.bus_drive_en !== 1'b0) begin
            n_bad++; $display("FAIL basic_drive_off: got %b want 0", bus_if.bus_drive_en);
        end
        bus_if.bgack_n = 1'b0;
        tick(2);
        n_total++;
        if (bus_if.bg_n !== 1'b0) begin
            n_bad++; $display("FAIL basic_bg_hold: got %b want 0", bus_if.bg_n);
        end
        tick(1);
        n_total++;
        if ({bus_if.bg_n, bus_if.ext_owner, bus_if.bus_drive_en} !== 3'b110) begin
            n_bad++; $display("FAIL basic_owned: got bg/own/drv=%b want 110",
                {bus_if.bg_n, bus_if.ext_owner, bus_if.bus_drive_en});
        end
        bus_if.br_n = 1'b1;
        tick(4);
        bus_if.bgack_n = 1'b1;
        tick(10);
        n_total++;
        if ({bus_if.bus_drive_en, bus_if.ext_owner} !== 2'b00) begin
            n_bad++; $display("FAIL basic_holdoff: got drv/own=%b want 00",
                {bus_if.bus_drive_en, bus_if.ext_owner});
        end
        tick(1);
        n_total++;
        if (bus_if.bus_drive_en !== 1'b1) begin
            n_bad++; $display("FAIL basic_drive_back: got %b want 1", bus_if.bus_drive_en);
        end
        n_total++;
        if (bus_if.grant_count !== 16'd1) begin
            n_bad++; $display("FAIL basic_count: got %0d want 1", bus_if.grant_count);
        end
    endtask

    task automatic test_mid_cycle();
        bus_if.engine_idle = 1'b0;
        bus_if.as_n        = 1'b0;
        bus_if.op_req_in   = 1'b1;
        tick(1);
        n_total++;
        if (bus_if.op_req_out !== 1'b1) begin
            n_bad++; $display("FAIL mid_req_fwd: got %b want 1", bus_if.op_req_out);
        end
        bus_if.br_n = 1'b0;
        tick(2);
        n_total++;
        if (bus_if.op_req_out !== 1'b0) begin
            n_bad++; $display("FAIL mid_req_block: got %b want 0", bus_if.op_req_out);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1);
            n_total++;
            if ({bus_if.bg_n, bus_if.op_req_out} !== 2'b10) begin
                n_bad++; $display("FAIL mid_wait[%0d]: got bg/req=%b want 10", i,
                    {bus_if.bg_n, bus_if.op_req_out});
            end
        end
        bus_if.as_n = 1'b1;
        tick(2);
        n_total++;
        if (bus_if.bg_n !== 1'b1) begin
            n_bad++; $display("FAIL mid_busy_engine: got %b want 1", bus_if.bg_n);
        end
        bus_if.engine_idle = 1'b1;
        tick(1);
        n_total++;
        if ({bus_if.bg_n, bus_if.op_req_out} !== 2'b00) begin
            n_bad++; $display("FAIL mid_grant: got bg/req=%b want 00",
                {bus_if.bg_n, bus_if.op_req_out});
        end
        bus_if.op_req_in = 1'b0;
        bus_if.bgack_n   = 1'b0;
        bus_if.br_n      = 1'b1;
        tick(3);
        bus_if.bgack_n = 1'b1;
        tick(11);
        n_total++;
        if (bus_if.grant_count !== 16'd2) begin
            n_bad++; $display("FAIL mid_count: got %0d want 2", bus_if.grant_count);
        end
    endtask

    task automatic test_timeout();
        bus_if.br_n = 1'b0;
        tick(4);
        n_total++;
        if (bus_if.bg_n !== 1'b0) begin
            n_bad++; $display("FAIL to_grant: got %b want 0", bus_if.bg_n);
        end
        bus_if.br_n = 1'b1;
        // two synchroniser clocks plus BG_TIMEOUT
        tick(65);
        n_total++;
        if (bus_if.bg_n !== 1'b0) begin
            n_bad++; $display("FAIL to_early: got %b want 0", bus_if.bg_n);
        end
        tick(1);
        n_total++;
        if (bus_if.bg_n !== 1'b1) begin
            n_bad++; $display("FAIL to_expire: got %b want 1", bus_if.bg_n);
        end
        n_total++;
        if ({bus_if.bus_drive_en, bus_if.grant_count} !== {1'b1, 16'd2}) begin
            n_bad++; $display("FAIL to_after: got drv=%b cnt=%0d want drv=1 cnt=2",
                bus_if.bus_drive_en, bus_if.grant_count);
        end
    endtask

    task automatic test_pi_turn();
        bus_if.br_n = 1'b0;
        tick(4);
        n_total++;
        if (bus_if.bg_n !== 1'b0) begin
            n_bad++; $display("FAIL pi_grant: got %b want 0", bus_if.bg_n);
        end
        bus_if.bgack_n   = 1'b0;
        bus_if.op_req_in = 1'b1;
        bus_if.br_n      = 1'b1;
        tick(3);
        n_total++;
        if ({bus_if.ext_owner, bus_if.op_req_out} !== 2'b10) begin
            n_bad++; $display("FAIL pi_owned: got own/req=%b want 10",
                {bus_if.ext_owner, bus_if.op_req_out});
        end
        tick(2);
        bus_if.br_n    = 1'b0;
        bus_if.bgack_n = 1'b1;
        tick(11);
        n_total++;
        if ({bus_if.op_req_out, bus_if.bg_n} !== 2'b11) begin
            n_bad++; $display("FAIL pi_turn_req: got req/bg=%b want 11",
                {bus_if.op_req_out, bus_if.bg_n});
        end
        n_total++;
        if (bus_if.grant_count !== 16'd3) begin
            n_bad++; $display("FAIL pi_count: got %0d want 3", bus_if.grant_count);
        end
        tick(5);
        n_total++;
        if ({bus_if.op_req_out, bus_if.bg_n} !== 2'b11) begin
            n_bad++; $display("FAIL pi_turn_hold: got req/bg=%b want 11",
                {bus_if.op_req_out, bus_if.bg_n});
        end
        bus_if.op_start = 1'b1;
        tick(1);
        bus_if.op_start = 1'b0;
        n_total++;
        if ({bus_if.op_req_out, bus_if.bg_n} !== 2'b01) begin
            n_bad++; $display("FAIL pi_turn_done: got req/bg=%b want 01",
                {bus_if.op_req_out, bus_if.bg_n});
        end
        tick(1);
        n_total++;
        if (bus_if.bg_n !== 1'b1) begin
            n_bad++; $display("FAIL pi_regrant_early: got %b want 1", bus_if.bg_n);
        end
        tick(1);
        n_total++;
        if (bus_if.bg_n !== 1'b0) begin
            n_bad++; $display("FAIL pi_regrant: got %b want 0", bus_if.bg_n);
        end
        bus_if.op_req_in = 1'b0;
        bus_if.bgack_n   = 1'b0;
        bus_if.br_n      = 1'b1;
        tick(3);
        bus_if.bgack_n = 1'b1;
        tick(11);
        n_total++;
        if (bus_if.grant_count !== 16'd4) begin
            n_bad++; $display("FAIL pi_count2: got %0d want 4", bus_if.grant_count);
        end
    endtask

    task automatic test_reset_mid_tenure();
        bus_if.br_n = 1'b0;
        tick(4);
        bus_if.bgack_n = 1'b0;
        bus_if.br_n    = 1'b1;
        tick(3);
        n_total++;
        if (bus_if.ext_owner !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_owned: got %b want 1", bus_if.ext_owner);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_total++;
        if ({bus_if.bg_n, bus_if.ext_owner, bus_if.bus_drive_en} !== 3'b100) begin
            n_bad++; $display("FAIL rst_mid_outs: got bg/own/drv=%b want 100",
                {bus_if.bg_n, bus_if.ext_owner, bus_if.bus_drive_en});
        end
        n_total++;
        if (bus_if.grant_count !== 16'd0) begin
            n_bad++; $display("FAIL rst_mid_count: got %0d want 0", bus_if.grant_count);
        end
        tick(5);
        n_total++;
        if ({bus_if.bg_n, bus_if.bus_drive_en} !== 2'b10) begin
            n_bad++; $display("FAIL rst_mid_hold: got bg/drv=%b want 10",
                {bus_if.bg_n, bus_if.bus_drive_en});
        end
        bus_if.bgack_n = 1'b1;
        tick(1);
        n_total++;
        if (bus_if.bus_drive_en !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_sync: got %b want 0", bus_if.bus_drive_en);
        end
        tick(1);
        n_total++;
        if (bus_if.bus_drive_en !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_drive: got %b want 1", bus_if.bus_drive_en);
        end
    endtask

    task automatic test_back_to_back();
        run_tenure();
        run_tenure();
        n_total++;
        if (bus_if.grant_count !== 16'd2) begin
            n_bad++; $display("FAIL b2b_count: got %0d want 2", bus_if.grant_count);
        end
        // Jump the counter next to its ceiling instead of 65k real tenures
        force dut.r_grant_count = 16'hFFFE;
        tick(1);
        release dut.r_grant_count;
        run_tenure();
        n_total++;
        if (bus_if.grant_count !== 16'hFFFF) begin
            n_bad++; $display("FAIL sat_reach: got %h want ffff", bus_if.grant_count);
        end
        run_tenure();
        n_total++;
        if (bus_if.grant_count !== 16'hFFFF) begin
            n_bad++; $display("FAIL sat_hold: got %h want ffff", bus_if.grant_count);
        end
        n_total++;
        if (bus_if.bus_drive_en !== 1'b1) begin
            n_bad++; $display("FAIL sat_drive: got %b want 1", bus_if.bus_drive_en);
        end
    endtask

    initial begin
        n_total            = 0;
        n_bad              = 0;
        reset              = 1'b1;
        bus_if.br_n        = 1'b1;
        bus_if.bgack_n     = 1'b1;
        bus_if.as_n        = 1'b1;
        bus_if.engine_idle = 1'b1;
        bus_if.op_req_in   = 1'b0;
        bus_if.op_start    = 1'b0;

        test_reset();
        test_basic_tenure();
        test_mid_cycle();
        test_timeout();
        test_pi_turn();
        test_reset_mid_tenure();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m68k_bus_arbiter.md
Name: m68k_bus_arbiter

Overview:
- Owns 68000 bus-mastership arbitration (BR_n/BG_n/BGACK_n) for the Pi-side transaction engine.
- Decides per cycle whether the engine may start a new Pi-requested bus cycle, or whether an external DMA master gets the bus.
- Controls the output enable of all engine-driven 68K bus signals.
- Sits between the Pi register interface (request source) and the 68K cycle state machine, in the c200m domain.

Parameters:
- SYNC_STAGES, 2, flops per input synchroniser on br_n and bgack_n (minimum 2).
- BG_TIMEOUT, 64, c200m cycles BG_n may stay low without BGACK after BR_n is withdrawn.
- HOLDOFF, 8, c200m cycles after BGACK_n release before bus drivers re-enable.

Ports:
- c200m  in  1  system clock (PI_CLK).
- reset  in  1  synchronous, active-high.
- br_n  in  1  M68K_BR_n, asynchronous.
- bgack_n  in  1  M68K_BGACK_n, asynchronous.
- as_n  in  1  engine's registered M68K_AS_n.
- engine_idle  in  1  high when the cycle engine is in Sr (waiting for a request).
- op_req_in  in  1  pending Pi transaction request.
- op_start  in  1  one-cycle pulse: engine accepted the request (S1 seen).
- op_req_out  out  1  request forwarded to the engine.
- bg_n  out  1  M68K_BG_n.
- bus_drive_en  out  1  enable for AS/UDS/LDS/RW/FC/address drivers.
- ext_owner  out  1  external master owns the bus.
- grant_count  out  16  saturating count of completed external tenures.

Behaviour:
- Reset values: bg_n=1, op_req_out=0, bus_drive_en=0, ext_owner=0, grant_count=0, state=IDLE, pi_turn=0, counters=0.
- br_s and bgack_s are the synchronised inputs. All decisions use the synchronised values only.

States:
- IDLE:
  - bus_drive_en = bgack_s (never drive while BGACK is low).
  - op_req_out = op_req_in && bgack_s && (br_s || pi_turn).
  - If !br_s && !pi_turn → WAIT_IDLE, and op_req_out is forced 0 from that cycle on.
  - If pi_turn: hold IDLE until op_start, then clear pi_turn. BR is not honoured before that.
  - If op_req_in drops while pi_turn is set, clear pi_turn.
- WAIT_IDLE:
  - op_req_out=0.
  - When engine_idle && as_n && !op_start → GRANT, with bg_n=0 on the next clock.
  - If br_s returns high before that → IDLE.
  - An op_start seen in this state (request accepted the same cycle BR arrived) lets that cycle complete. Stay in WAIT_IDLE.
- GRANT:
  - bg_n=0; bus_drive_en=0 on entry, so drivers are off the cycle after bg_n falls.
  - If !bgack_s → OWNED.
  - Else if br_s, increment the timeout counter. On reaching BG_TIMEOUT → IDLE with bg_n=1 (withdrawn request). Counter clears whenever br_s is low.
- OWNED:
  - bg_n=1 on entry (68000 rule: negate BG once BGACK is asserted); ext_owner=1; bus_drive_en=0.
  - If bgack_s → RELEASE.
  - If br_s=0 while in OWNED, stay in OWNED: the master keeps the bus until BGACK releases.
- RELEASE:
  - ext_owner=0; increment grant_count (saturates at 16'hFFFF).
  - Count HOLDOFF cycles, then → IDLE.
  - Set pi_turn=1 if op_req_in is high at exit. This gives the Pi one transaction before the next grant (no starvation).
  - If bgack_s falls during holdoff → OWNED, with no count increment.

Priorities and boundary rules:
- Simultaneous new op_req_in and BR in IDLE with pi_turn=0: external master wins.
- Reset mid-tenure: bg_n high next clock, state IDLE. bus_drive_en stays 0 until bgack_s is seen high.
- op_req_out is level and combinationally gated by state. It is never asserted outside IDLE.

Latency:
- BR_n pin to bg_n low: SYNC_STAGES+2 clocks when the engine is idle.
- BGACK_n pin release to bus_drive_en high: SYNC_STAGES+HOLDOFF+1 clocks.

Test Plan:
- Engine idle, br_n falls → bg_n low at cycle SYNC_STAGES+2. bgack_n low → bg_n high and ext_owner=1. bgack_n high → bus_drive_en=1 after HOLDOFF+SYNC_STAGES+1 clocks; grant_count=1.
- Engine mid-cycle (engine_idle=0, as_n=0), br_n falls → bg_n stays 1 until as_n=1 and engine_idle=1, then falls within 1 clock; op_req_out=0 throughout.
- br_n low, then high after bg_n falls, no bgack → bg_n returns 1 exactly BG_TIMEOUT clocks after br_s rises; grant_count unchanged.
- op_req_in held high during a tenure with br_n re-asserted at release → op_req_out=1 in IDLE; bg_n stays 1 until op_start, then the arbiter re-grants.
- reset asserted in OWNED with bgack_n still low → bg_n=1, bus_drive_en=0 until bgack_n high plus sync delay; grant_count=0.
- 70000 back-to-back tenures → grant_count saturates at 65535.
